// File: rtl/imem_arbiter.sv
// ============================================================================
// Module   : imem_arbiter
// Purpose  : Shares the single-ported instruction memory between instruction
//            fetch and the loader/debug port, and routes read data back to
//            the owner. Optional macro IMEM_ARB_STARVE_EN adds loader
//            anti-starvation.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module imem_arbiter #(
   parameter int MEM_BYTES  = 4096,
   parameter int STARVE_LIM = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        f_req,
   input  logic [31:0] f_addr,
   output logic        f_gnt,
   output logic        f_rvalid,
   output logic [31:0] f_rdata,
   output logic        f_err,
   input  logic        l_req,
   input  logic        l_we,
   input  logic [31:0] l_addr,
   input  logic [31:0] l_wdata,
   output logic        l_gnt,
   output logic        l_rvalid,
   output logic [31:0] l_rdata,
   output logic        l_err,
   output logic        m_write_en,
   output logic [31:0] m_addr,
   output logic [31:0] m_write_data,
   input  logic [31:0] m_read_data
);

   localparam logic [31:0] c_max_addr = 32'(MEM_BYTES - 4);

   logic w_f_ok;
   logic w_l_ok;
   logic w_force;
   logic r_pend;
   logic r_owner;
   logic r_err;

   assign w_f_ok = (f_addr[1:0] == 2'b00) && (f_addr <= c_max_addr);
   assign w_l_ok = (l_addr[1:0] == 2'b00) && (l_addr <= c_max_addr);

`ifdef IMEM_ARB_STARVE_EN
   logic [3:0] r_starve_cnt;

   // Counter reaches STARVE_LIM only after STARVE_LIM denied cycles in a row.
   assign w_force = l_req & (r_starve_cnt >= 4'(STARVE_LIM));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_starve_cnt <= 4'd0;
      end else if (l_req & ~l_gnt) begin
         r_starve_cnt <= r_starve_cnt + 4'd1;
      end else begin
         r_starve_cnt <= 4'd0;
      end
   end
`else
   localparam int c_unused_starve_lim = STARVE_LIM;
   assign w_force = 1'b0;
`endif

   always_comb begin
      f_gnt        = f_req & ~w_force;
      l_gnt        = l_req & (~f_req | w_force);
      m_write_en   = 1'b0;
      m_addr       = 32'd0;
      m_write_data = 32'd0;
      if (l_gnt) begin
         m_addr       = l_addr;
         m_write_data = l_wdata;
         m_write_en   = l_we & w_l_ok;
      end else if (f_gnt) begin
         m_addr = f_addr;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pend  <= 1'b0;
         r_owner <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_pend <= f_gnt | l_gnt;
         if (f_gnt | l_gnt) begin
            r_owner <= l_gnt;
            r_err   <= l_gnt ? ~w_l_ok : ~w_f_ok;
         end
      end
   end

   assign f_rvalid = r_pend & ~r_owner;
   assign l_rvalid = r_pend & r_owner;
   assign f_err    = f_rvalid & r_err;
   assign l_err    = l_rvalid & r_err;
   assign f_rdata  = m_read_data;
   assign l_rdata  = m_read_data;

endmodule

`default_nettype wire

// File: tb/tb_imem_arbiter.sv
// ============================================================================
// Module   : tb_imem_arbiter
// Purpose  : Self-checking bench for imem_arbiter with a behavioural memory
//            and a transaction-level reference model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_imem_arbiter;

   localparam int MEM_BYTES  = 4096;
   localparam int STARVE_LIM = 2;
`ifdef IMEM_ARB_STARVE_EN
   localparam bit STARVE_EN = 1'b1;
`else
   localparam bit STARVE_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        f_req = 1'b0;
   logic [31:0] f_addr = 32'd0;
   logic        f_gnt, f_rvalid, f_err;
   logic [31:0] f_rdata;
   logic        l_req = 1'b0;
   logic        l_we = 1'b0;
   logic [31:0] l_addr = 32'd0;
   logic [31:0] l_wdata = 32'd0;
   logic        l_gnt, l_rvalid, l_err;
   logic [31:0] l_rdata;
   logic        m_write_en;
   logic [31:0] m_addr, m_write_data;
   logic [31:0] m_read_data;

   int n_checks = 0;
   int n_errors = 0;

   imem_arbiter #(.MEM_BYTES(MEM_BYTES), .STARVE_LIM(STARVE_LIM)) dut (
      .clk(clk), .rst(rst),
      .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid),
      .f_rdata(f_rdata), .f_err(f_err),
      .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
      .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata), .l_err(l_err),
      .m_write_en(m_write_en), .m_addr(m_addr), .m_write_data(m_write_data),
      .m_read_data(m_read_data)
   );

   always #5 clk = ~clk;

   function automatic bit addr_ok(input logic [31:0] a);
      return (a[1:0] == 2'b00) && (a <= 32'(MEM_BYTES - 4));
   endfunction

   // Memory the DUT drives; bad addresses read back as all ones.
   logic [31:0] mem [0:MEM_BYTES/4-1];
   always @(posedge clk) begin
      if (m_write_en) mem[m_addr[11:2]] <= m_write_data;
      m_read_data <= addr_ok(m_addr) ? mem[m_addr[11:2]] : 32'hFFFF_FFFF;
   end

   // Reference model state: shadow memory plus one outstanding response.
   logic [31:0] shadow [0:MEM_BYTES/4-1];
   int          m_denied;
   bit          m_pend, m_owner, m_err;
   logic [31:0] m_data;
   bit          e_fg, e_lg, e_we, e_fv, e_lv, e_ferr, e_lerr;
   logic [31:0] e_addr, e_wdata, e_rdata;

   task automatic model_reset();
      m_pend = 0; m_owner = 0; m_err = 0; m_denied = 0;
   endtask

   task automatic drive(input bit fr, input logic [31:0] fa, input bit lr,
                        input bit lwe, input logic [31:0] la, input logic [31:0] lwd);
      bit frc;
      f_req = fr; f_addr = fa; l_req = lr; l_we = lwe; l_addr = la; l_wdata = lwd;
      frc     = STARVE_EN && lr && (m_denied >= STARVE_LIM);
      e_fg    = fr && !frc;
      e_lg    = lr && (!fr || frc);
      e_addr  = e_lg ? la : (e_fg ? fa : 32'd0);
      e_we    = e_lg && lwe && addr_ok(la);
      e_wdata = lwd;
      e_fv    = m_pend && !m_owner;
      e_lv    = m_pend && m_owner;
      e_ferr  = e_fv && m_err;
      e_lerr  = e_lv && m_err;
      e_rdata = m_data;
      @(negedge clk);
   endtask

   task automatic tick();
      logic [31:0] a;
      @(posedge clk);
      if (e_fg || e_lg) begin
         a       = e_lg ? l_addr : f_addr;
         m_pend  = 1;
         m_owner = e_lg;
         m_err   = !addr_ok(a);
         m_data  = addr_ok(a) ? shadow[a[11:2]] : 32'hFFFF_FFFF;
         if (e_we) shadow[a[11:2]] = l_wdata;
      end else begin
         m_pend = 0;
      end
      m_denied = (l_req && !e_lg) ? m_denied + 1 : 0;
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if ({f_rvalid, l_rvalid, f_err, l_err, f_gnt, l_gnt, m_write_en} !== 7'b0 || m_addr !== 32'd0) begin
         n_errors++;
         $display("FAIL reset_state: got rv/err/gnt/we=%b addr=%h, want 0", {f_rvalid, l_rvalid, f_err, l_err, f_gnt, l_gnt, m_write_en}, m_addr);
      end
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;
      model_reset();
      drive(0, 0, 0, 0, 0, 0);
      n_checks++;
      if ({f_rvalid, l_rvalid} !== 2'b00) begin
         n_errors++;
         $display("FAIL post_reset_rvalid: got %b want 00", {f_rvalid, l_rvalid});
      end
      tick();
   endtask

   task automatic test_fetch_read();
      mem[4] = 32'h0050_0093; shadow[4] = 32'h0050_0093;
      drive(1, 32'h10, 0, 0, 0, 0);
      n_checks++;
      if ({f_gnt, l_gnt, m_addr} !== {2'b10, 32'h10}) begin
         n_errors++;
         $display("FAIL fetch_grant: got gnt=%b addr=%h want 10/00000010", {f_gnt, l_gnt}, m_addr);
      end
      tick();
      drive(0, 0, 0, 0, 0, 0);
      n_checks++;
      if ({f_rvalid, f_err, l_rvalid} !== 3'b100 || f_rdata !== 32'h0050_0093) begin
         n_errors++;
         $display("FAIL fetch_resp: got v/e/lv=%b data=%h want 100/00500093", {f_rvalid, f_err, l_rvalid}, f_rdata);
      end
      tick();
   endtask

   task automatic test_write_then_fetch();
      logic [31:0] old;
      old = shadow[8];
      drive(0, 0, 1, 1, 32'h20, 32'hDEAD_BEEF);
      n_checks++;
      if ({l_gnt, m_write_en, m_addr, m_write_data} !== {2'b11, 32'h20, 32'hDEAD_BEEF}) begin
         n_errors++;
         $display("FAIL loader_write_drive: got gnt/we=%b addr=%h wd=%h", {l_gnt, m_write_en}, m_addr, m_write_data);
      end
      tick();
      drive(1, 32'h20, 0, 0, 0, 0);
      n_checks++;
      if (l_rvalid !== 1'b1 || l_rdata !== old) begin
         n_errors++;
         $display("FAIL write_old_data: got v=%b data=%h want 1/%h", l_rvalid, l_rdata, old);
      end
      tick();
      drive(0, 0, 0, 0, 0, 0);
      n_checks++;
      if (f_rvalid !== 1'b1 || f_rdata !== 32'hDEAD_BEEF) begin
         n_errors++;
         $display("FAIL fetch_after_write: got v=%b data=%h want 1/deadbeef", f_rvalid, f_rdata);
      end
      tick();
   endtask

   task automatic test_contention();
      logic [2:0] got, want;
      got  = 3'b000;
      want = STARVE_EN ? 3'b001 : 3'b000;
      drive(0, 0, 0, 0, 0, 0);
      tick();
      for (int i = 0; i < 3; i++) begin
         drive(1, 32'h40, 1, 0, 32'h44, 0);
         n_checks++;
         if ((f_gnt & l_gnt) !== 1'b0 || {f_gnt, l_gnt} !== {e_fg, e_lg}) begin
            n_errors++;
            $display("FAIL contention_gnt[%0d]: got %b want %b", i, {f_gnt, l_gnt}, {e_fg, e_lg});
         end
         got = {got[1:0], l_gnt};
         tick();
      end
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL contention_order: loader grants got %b want %b", got, want);
      end
      drive(0, 0, 0, 0, 0, 0);
      tick();
   endtask

   task automatic test_bad_write();
      logic [31:0] old;
      logic [31:0] bad [2];
      old    = mem[8];
      bad[0] = 32'h22;
      bad[1] = 32'(MEM_BYTES);
      for (int i = 0; i < 2; i++) begin
         drive(0, 0, 1, 1, bad[i], 32'h1234_5678);
         n_checks++;
         if ({l_gnt, m_write_en} !== 2'b10) begin
            n_errors++;
            $display("FAIL bad_write_we[%0d]: got gnt/we=%b want 10", i, {l_gnt, m_write_en});
         end
         if (i == 1) begin
            n_checks++;
            if ({l_rvalid, l_err} !== 2'b11 || l_rdata !== 32'hFFFF_FFFF) begin
               n_errors++;
               $display("FAIL bad_write_resp0: got v/e=%b data=%h want 11/ffffffff", {l_rvalid, l_err}, l_rdata);
            end
         end
         tick();
      end
      drive(0, 0, 0, 0, 0, 0);
      n_checks++;
      if ({l_rvalid, l_err} !== 2'b11 || l_rdata !== 32'hFFFF_FFFF) begin
         n_errors++;
         $display("FAIL bad_write_resp1: got v/e=%b data=%h want 11/ffffffff", {l_rvalid, l_err}, l_rdata);
      end
      tick();
      n_checks++;
      if (mem[8] !== old || shadow[8] !== old) begin
         n_errors++;
         $display("FAIL bad_write_mem: got %h want %h", mem[8], old);
      end
   endtask

   task automatic test_back_to_back();
      logic [2:0] fv, lv;
      fv = 3'b000; lv = 3'b000;
      drive(1, 32'h0, 0, 0, 0, 0);                       tick();
      for (int i = 0; i < 3; i++) begin
         if (i == 0)      drive(0, 0, 1, 0, 32'h4, 0);
         else if (i == 1) drive(1, 32'h8, 0, 0, 0, 0);
         else             drive(0, 0, 0, 0, 0, 0);
         fv = {fv[1:0], f_rvalid};
         lv = {lv[1:0], l_rvalid};
         n_checks++;
         if ((e_fv && f_rdata !== e_rdata) || (e_lv && l_rdata !== e_rdata)) begin
            n_errors++;
            $display("FAIL b2b_data[%0d]: got f=%h l=%h want %h", i, f_rdata, l_rdata, e_rdata);
         end
         tick();
      end
      n_checks++;
      if ({fv, lv} !== 6'b101_010) begin
         n_errors++;
         $display("FAIL b2b_order: got f=%b l=%b want 101/010", fv, lv);
      end
   endtask

   task automatic test_reset_mid();
      drive(1, 32'h10, 1, 0, 32'h14, 0);
      tick();
      drive(0, 0, 0, 0, 0, 0);
      rst = 1'b1;
      #1;
      n_checks++;
      if ({f_rvalid, l_rvalid, f_err, l_err} !== 4'b0) begin
         n_errors++;
         $display("FAIL reset_mid_rvalid: got %b want 0000", {f_rvalid, l_rvalid, f_err, l_err});
      end
      model_reset();
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) begin
         drive(i > 0, 32'h10, i > 0, 0, 32'h14, 0);
         n_checks++;
         if ({f_gnt, l_gnt, f_rvalid, l_rvalid} !== {e_fg, e_lg, e_fv, e_lv}) begin
            n_errors++;
            $display("FAIL reset_restart[%0d]: got %b want %b", i, {f_gnt, l_gnt, f_rvalid, l_rvalid}, {e_fg, e_lg, e_fv, e_lv});
         end
         tick();
      end
   endtask

   task automatic test_random();
      logic [31:0] a [2];
      for (int i = 0; i < 400; i++) begin
         for (int k = 0; k < 2; k++) begin
            case ($urandom_range(0, 9))
               0:       a[k] = 32'($urandom_range(0, MEM_BYTES / 4 - 1)) * 4 + 32'($urandom_range(1, 3));
               1:       a[k] = 32'(MEM_BYTES) + 32'($urandom_range(0, 64)) * 4;
               2:       a[k] = 32'(MEM_BYTES - 4);
               default: a[k] = 32'($urandom_range(0, 15)) * 4;
            endcase
         end
         drive(($urandom_range(0, 2) != 0), a[0], ($urandom_range(0, 1) != 0),
               ($urandom_range(0, 1) != 0), a[1], $urandom);
         n_checks++;
         if ({f_gnt, l_gnt, m_write_en, f_rvalid, l_rvalid, f_err, l_err} !==
             {e_fg, e_lg, e_we, e_fv, e_lv, e_ferr, e_lerr}) begin
            n_errors++;
            $display("FAIL rand_ctrl[%0d]: got %b want %b", i,
                     {f_gnt, l_gnt, m_write_en, f_rvalid, l_rvalid, f_err, l_err},
                     {e_fg, e_lg, e_we, e_fv, e_lv, e_ferr, e_lerr});
         end
         n_checks++;
         if (m_addr !== e_addr || (e_we && m_write_data !== e_wdata)) begin
            n_errors++;
            $display("FAIL rand_mem[%0d]: got addr=%h wd=%h want addr=%h wd=%h", i, m_addr, m_write_data, e_addr, e_wdata);
         end
         n_checks++;
         if ((e_fv && f_rdata !== e_rdata) || (e_lv && l_rdata !== e_rdata)) begin
            n_errors++;
            $display("FAIL rand_data[%0d]: got f=%h l=%h want %h", i, f_rdata, l_rdata, e_rdata);
         end
         tick();
      end
   endtask

   initial begin
      for (int i = 0; i < MEM_BYTES / 4; i++) begin
         mem[i]    = $urandom;
         shadow[i] = mem[i];
      end
      model_reset();
      test_reset();
      test_fetch_read();
      test_write_then_fetch();
      test_contention();
      test_bad_write();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
